// File: rtl/fft_fifo_rd_pkg.sv
// Shared types and defaults for the FFT->HDMI FIFO frame reader.
//   rd_state_e      : reader FSM states
//   DATA_WIDTH_DEF  : default magnitude word width
//   BIN_W_DEF       : default bin index width
//   SKID_DEPTH      : output skid buffer depth (credit limit for FIFO pops)
package fft_fifo_rd_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_LVL, BURST, DRAIN} rd_state_e;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int BIN_W_DEF      = 10;
  localparam int SKID_DEPTH     = 2;
endpackage

// File: rtl/fft_rd_skid_buf.sv
// Two-entry valid/ready buffer between the FIFO read port and the stream output.
// Ports:
//   clk_tb, tb_rst      : clock, async active-high reset
//   in_valid, in_data   : captured FIFO word (no ready; the producer holds credits)
//   out_valid, out_data : head entry, held stable until out_ready
//   out_ready           : consumer ready
//   count               : occupancy 0..2, used by the producer's credit check
module fft_rd_skid_buf
  import fft_fifo_rd_pkg::*;
#(
  parameter int W = 27
) (
  input  logic         clk_tb,
  input  logic         tb_rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);
  logic [SKID_DEPTH-1:0][W-1:0] mem;
  // One-bit pointers: depth is fixed at two entries.
  logic rd_ptr, wr_ptr;
  logic pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_valid) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // Push and pop in the same cycle leave the occupancy unchanged.
      case ({in_valid, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fft_fifo_frame_reader.sv
// Read-side controller for the FFT->HDMI async FIFO. Waits until a whole frame is
// buffered, pops FRAME_LEN words and streams them out tagged with their bin index.
// Ports:
//   clk_tb, tb_rst          : read-domain clock, async active-high reset
//   frame_req               : pulse from renderer, honoured only in IDLE
//   fifo_rd_data/_empty/_rd_water_level, fifo_rd_en : FIFO read port
//   m_data, m_bin, m_valid, m_last, m_ready         : output stream
//   busy, frame_done, underrun_err                  : status
// Optional feature (macro FFT_PEAK_TRACK_EN): peak_mag, peak_bin, peak_valid report
// the largest non-DC magnitude of the frame (lowest bin wins ties).
module fft_fifo_frame_reader
  import fft_fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_LEN  = 1024,
  parameter int BIN_W      = BIN_W_DEF
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  frame_req,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [BIN_W-1:0]      m_bin,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
`ifdef FFT_PEAK_TRACK_EN
  output logic [DATA_WIDTH-1:0] peak_mag,
  output logic [BIN_W-1:0]      peak_bin,
  output logic                  peak_valid,
`endif
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun_err
);
  localparam int                SKID_W    = DATA_WIDTH + BIN_W + 1;
  localparam logic [ADDR_WIDTH:0] FRAME_LVL = (ADDR_WIDTH+1)'(FRAME_LEN);
  localparam logic [BIN_W:0]    POPS_FULL = (BIN_W+1)'(FRAME_LEN);
  localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(FRAME_LEN - 1);

  rd_state_e         state_q, state_d;
  logic [BIN_W:0]    pops_q;
  logic              inflight_q;
  logic [BIN_W-1:0]  cap_bin_q;
  logic              underrun_q, frame_done_q;
  logic [1:0]        skid_cnt;
  logic [2:0]        credit_used;
  logic [SKID_W-1:0] skid_out;
  logic              rd_en, beat, frame_start;

  assign frame_start = (state_q == IDLE) & frame_req;
  assign beat        = m_valid & m_ready;
  // Words in the buffer plus the one on its way from the FIFO must leave room.
  assign credit_used = {1'b0, skid_cnt} + {2'b0, inflight_q};

  always_comb begin
    state_d = state_q;
    rd_en   = (state_q == BURST) & ~fifo_empty & (pops_q < POPS_FULL) & (credit_used < 3'd2);
    case (state_q)
      IDLE:     if (frame_req) state_d = WAIT_LVL;
      WAIT_LVL: if (fifo_rd_water_level >= FRAME_LVL) state_d = BURST;
      BURST:    if (rd_en && (pops_q == POPS_FULL - 1'b1)) state_d = DRAIN;
      DRAIN:    if (beat && m_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      state_q      <= IDLE;
      pops_q       <= '0;
      inflight_q   <= 1'b0;
      cap_bin_q    <= '0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= rd_en;
      frame_done_q <= beat & m_last;
      if (frame_start) begin
        pops_q     <= '0;
        cap_bin_q  <= '0;
        underrun_q <= 1'b0;
      end else begin
        if (rd_en) pops_q <= pops_q + 1'b1;
        // Bin is assigned at capture; capture order equals output order.
        if (inflight_q) cap_bin_q <= (cap_bin_q == LAST_BIN) ? '0 : cap_bin_q + 1'b1;
        if (state_q == BURST && pops_q < POPS_FULL && fifo_empty) underrun_q <= 1'b1;
      end
    end
  end

  fft_rd_skid_buf #(.W(SKID_W)) u_skid (
    .clk_tb    (clk_tb),
    .tb_rst    (tb_rst),
    .in_valid  (inflight_q),
    .in_data   ({cap_bin_q == LAST_BIN, cap_bin_q, fifo_rd_data}),
    .out_valid (m_valid),
    .out_data  (skid_out),
    .out_ready (m_ready),
    .count     (skid_cnt)
  );

  assign {m_last, m_bin, m_data} = skid_out;
  assign fifo_rd_en   = rd_en;
  assign busy         = (state_q != IDLE);
  assign frame_done   = frame_done_q;
  assign underrun_err = underrun_q;

`ifdef FFT_PEAK_TRACK_EN
  // DC bin is excluded; strict compare keeps the lowest bin on ties.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      peak_mag <= '0;
      peak_bin <= '0;
    end else if (frame_start) begin
      peak_mag <= '0;
      peak_bin <= '0;
    end else if (beat && (m_bin != '0) && (m_data > peak_mag)) begin
      peak_mag <= m_data;
      peak_bin <= m_bin;
    end
  end
  assign peak_valid = frame_done_q;
`endif
endmodule
